// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// stall-vector bit positions and bus-width constants.
// ---------------------------------------------------------------------------
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int STALL_W     = 6;

    // Bit of the ctrl stall vector that freezes the IF stage.
    localparam int STALL_IF_BIT = 1;

    localparam logic STOP     = 1'b1;
    localparam logic NOT_STOP = 1'b0;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    // IDLE    : first cycle after reset, no request yet
    // WAIT    : request to pc outstanding
    // HOLD    : instruction captured during a stall, bus idle
    // DISCARD : waiting for the ack of a fetch made stale by a flush
    typedef enum logic [1:0] {
        IF_ST_IDLE    = 2'd0,
        IF_ST_WAIT    = 2'd1,
        IF_ST_HOLD    = 2'd2,
        IF_ST_DISCARD = 2'd3
    } if_state_e;

    // Sequential next PC; 32-bit modular, wraps from 0xFFFF_FFFC to 0.
    function automatic logic [INST_ADDR_W-1:0] seq_pc(input logic [INST_ADDR_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage. Holds the PC, issues single-outstanding requests on
// the instruction bus and presents if_pc/if_inst when an instruction is ready.
// Branch redirects take effect after the delay-slot instruction is consumed;
// an exception flush redirects immediately and discards any stale in-flight
// fetch.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall[5:0]          ctrl stall vector; only stall[1] (IF) is used
//   flush, new_pc       exception flush and its target (highest priority)
//   branch_flag_i       taken branch/jump resolved in ID
//   branch_target_i     branch target
//   ibus_req/ibus_addr  fetch request, held until ibus_ack
//   ibus_ack/ibus_rdata one-cycle completion and instruction word
//   if_pc/if_inst       presented PC / instruction (zero when none)
//   stallreq            IF cannot supply an instruction this cycle
// ---------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] new_pc,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    output logic                   ibus_req,
    output logic [INST_ADDR_W-1:0] ibus_addr,
    input  logic                   ibus_ack,
    input  logic [INST_W-1:0]      ibus_rdata,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0]      if_inst,
    output logic                   stallreq
);

    if_state_e              state_q, state_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0]      buf_inst_q, buf_inst_d;
    logic                   br_pend_q, br_pend_d;
    logic [INST_ADDR_W-1:0] br_tgt_q, br_tgt_d;
    // Address of the abandoned fetch, kept on the bus until its ack arrives.
    logic [INST_ADDR_W-1:0] stale_addr_q, stale_addr_d;

    logic                   if_stop;
    logic                   avail;
    logic                   consume;
    logic [INST_ADDR_W-1:0] pc_after;

    // Only the IF bit of the stall vector matters here.
    logic unused_stall;
    assign unused_stall = ^{stall[STALL_W-1:STALL_IF_BIT+1], stall[STALL_IF_BIT-1:0]};

    assign if_stop  = (stall[STALL_IF_BIT] == STOP);
    assign avail    = ((state_q == IF_ST_WAIT) && ibus_ack) || (state_q == IF_ST_HOLD);
    assign consume  = avail && !if_stop && !flush;

    // A branch seen together with the consumed delay slot wins over a latched one.
    assign pc_after = branch_flag_i ? branch_target_i :
                      br_pend_q     ? br_tgt_q        : seq_pc(pc_q);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_inst_d   = buf_inst_q;
        br_pend_d    = br_pend_q;
        br_tgt_d     = br_tgt_q;
        stale_addr_d = stale_addr_q;

        if (branch_flag_i && !consume) begin
            br_pend_d = 1'b1;
            br_tgt_d  = branch_target_i;
        end
        if (consume) begin
            pc_d      = pc_after;
            br_pend_d = 1'b0;
        end

        if (state_q == IF_ST_IDLE) begin
            state_d = IF_ST_WAIT;
        end else if (flush) begin
            pc_d       = new_pc;
            br_pend_d  = 1'b0;
            buf_inst_d = ZERO_WORD;
            if (((state_q == IF_ST_WAIT) || (state_q == IF_ST_DISCARD)) && !ibus_ack) begin
                state_d = IF_ST_DISCARD;
                // Re-flush while already discarding keeps the original stale address.
                if (state_q == IF_ST_WAIT) begin
                    stale_addr_d = pc_q;
                end
            end else begin
                state_d = IF_ST_WAIT;
            end
        end else begin
            case (state_q)
                IF_ST_WAIT: begin
                    if (ibus_ack && !consume) begin
                        buf_inst_d = ibus_rdata;
                        state_d    = IF_ST_HOLD;
                    end
                end
                IF_ST_HOLD: begin
                    if (consume) begin
                        state_d = IF_ST_WAIT;
                    end
                end
                IF_ST_DISCARD: begin
                    if (ibus_ack) begin
                        state_d = IF_ST_WAIT;
                    end
                end
                default: state_d = IF_ST_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IF_ST_IDLE;
            pc_q         <= RESET_PC;
            buf_inst_q   <= ZERO_WORD;
            br_pend_q    <= 1'b0;
            br_tgt_q     <= '0;
            stale_addr_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_inst_q   <= buf_inst_d;
            br_pend_q    <= br_pend_d;
            br_tgt_q     <= br_tgt_d;
            stale_addr_q <= stale_addr_d;
        end
    end

    // Outputs are forced to their idle values during reset so that nothing
    // left over in the registers is visible in the reset cycle.
    assign ibus_req  = ((state_q == IF_ST_WAIT) || (state_q == IF_ST_DISCARD)) && !rst;
    assign ibus_addr = rst ? RESET_PC :
                       (state_q == IF_ST_DISCARD) ? stale_addr_q : pc_q;
    assign if_pc     = rst ? RESET_PC : pc_q;
    assign stallreq  = !rst && !avail && !flush;

    always_comb begin
        if_inst = ZERO_WORD;
        if (!rst && !flush) begin
            if ((state_q == IF_ST_WAIT) && ibus_ack) begin
                if_inst = ibus_rdata;
            end else if (state_q == IF_ST_HOLD) begin
                if_inst = buf_inst_q;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
// Directed bench for if_fetch. A behavioural instruction memory returns
// addr ^ 32'hDEAD_BEEF after a programmable ack latency. The driver pushes
// the expected consumed (pc, inst) pairs into a queue; a monitor pops one
// each time the stage hands an instruction to ID.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .new_pc          (new_pc),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .ibus_req        (ibus_req),
        .ibus_addr       (ibus_addr),
        .ibus_ack        (ibus_ack),
        .ibus_rdata      (ibus_rdata),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .stallreq        (stallreq)
    );

    // ---------------- memory model ----------------
    int lat;
    int cnt;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    always_comb begin
        ibus_ack   = ibus_req && (cnt == lat);
        ibus_rdata = mem_data(ibus_addr);
    end

    always @(posedge clk) begin
        if (rst || !ibus_req || ibus_ack) cnt <= 0;
        else                              cnt <= cnt + 1;
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = mem_data(pc);
        exp_q.push_back(e);
    endtask

    // Monitor: one line per consumed instruction.
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && !stallreq && !flush && !stall[1]) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_consume: got pc 0x%08h inst 0x%08h expected none", if_pc, if_inst);
            end else begin
                e = exp_q.pop_front();
                $display("consume pc=0x%08h inst=0x%08h", if_pc, if_inst);
                chk("consume_pc", if_pc, e.pc);
                chk("consume_inst", if_inst, e.inst);
            end
        end
        if (!rst && prev_req && !prev_ack && ibus_req)
            chk("addr_stable", ibus_addr, prev_addr);
        prev_req  <= ibus_req && !rst;
        prev_ack  <= ibus_ack;
        prev_addr <= ibus_addr;
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = '0;
        flush = 1'b0;
        new_pc = '0;
        branch_flag_i = 1'b0;
        branch_target_i = '0;
        lat = 0;
        step();
        probe();
        chk("rst_ibus_req", {31'd0, ibus_req}, 32'd0);
        chk("rst_ibus_addr", ibus_addr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_stallreq", {31'd0, stallreq}, 32'd0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        lat = 0;
        stall = '0;
        flush = 1'b0;
        new_pc = '0;
        branch_flag_i = 1'b0;
        branch_target_i = '0;
        step();

        // --- zero-wait stream from reset ---
        do_reset();
        for (int i = 0; i < 4; i++) push(32'(i * 4));
        probe();
        chk("idle_req", {31'd0, ibus_req}, 32'd0);
        chk("idle_stallreq", {31'd0, stallreq}, 32'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            probe();
            chk("zw_stallreq", {31'd0, stallreq}, 32'd0);
            chk("zw_addr", ibus_addr, 32'(i * 4));
            step();
        end

        // --- 2-cycle ack latency ---
        do_reset();
        lat = 2;
        push(32'h0);
        push(32'h4);
        step();
        for (int i = 0; i < 6; i++) begin
            probe();
            chk("lat2_stallreq", {31'd0, stallreq}, (i % 3 != 2) ? 32'd1 : 32'd0);
            step();
        end

        // --- ack at 0x10 during a 3-cycle IF stall ---
        do_reset();
        for (int i = 0; i < 6; i++) push(32'(i * 4));
        for (int i = 0; i < 5; i++) step();
        stall = 6'b000010;
        probe();
        chk("hold_entry_addr", ibus_addr, 32'h10);
        chk("hold_entry_req", {31'd0, ibus_req}, 32'd1);
        step();
        for (int i = 0; i < 2; i++) begin
            probe();
            chk("hold_req", {31'd0, ibus_req}, 32'd0);
            chk("hold_stallreq", {31'd0, stallreq}, 32'd0);
            chk("hold_inst", if_inst, mem_data(32'h10));
            step();
        end
        stall = '0;
        probe();
        chk("hold_release_pc", if_pc, 32'h10);
        step();
        probe();
        chk("hold_next_addr", ibus_addr, 32'h14);
        step();

        // --- branch while waiting on delay slot at 0x20 ---
        do_reset();
        for (int i = 0; i < 9; i++) push(32'(i * 4));
        push(32'h100);
        for (int i = 0; i < 9; i++) step();
        lat = 2;
        branch_flag_i = 1'b1;
        branch_target_i = 32'h100;
        probe();
        chk("br_slot_addr", ibus_addr, 32'h20);
        step();
        branch_flag_i = 1'b0;
        branch_target_i = '0;
        probe();
        chk("br_wait_stallreq", {31'd0, stallreq}, 32'd1);
        step();
        probe();
        chk("br_slot_pc", if_pc, 32'h20);
        step();
        probe();
        chk("br_target_addr", ibus_addr, 32'h100);
        chk("br_target_req", {31'd0, ibus_req}, 32'd1);
        step();
        step();
        step();

        // --- flush with a stale fetch outstanding at 0x40 ---
        do_reset();
        push(32'h0);
        push(32'h180);
        step();
        branch_flag_i = 1'b1;
        branch_target_i = 32'h40;
        step();
        branch_flag_i = 1'b0;
        branch_target_i = '0;
        lat = 2;
        probe();
        chk("fl_addr_before", ibus_addr, 32'h40);
        step();
        flush = 1'b1;
        new_pc = 32'h180;
        probe();
        chk("fl_cycle_inst", if_inst, 32'd0);
        chk("fl_cycle_stallreq", {31'd0, stallreq}, 32'd0);
        step();
        flush = 1'b0;
        new_pc = '0;
        probe();
        chk("discard_addr", ibus_addr, 32'h40);
        chk("discard_req", {31'd0, ibus_req}, 32'd1);
        chk("discard_ack", {31'd0, ibus_ack}, 32'd1);
        chk("discard_inst", if_inst, 32'd0);
        chk("discard_stallreq", {31'd0, stallreq}, 32'd1);
        step();
        probe();
        chk("fl_new_addr", ibus_addr, 32'h180);
        step();
        step();
        step();

        // --- PC wrap at 0xFFFF_FFFC ---
        do_reset();
        push(32'h0);
        push(32'hFFFF_FFFC);
        push(32'h0);
        step();
        branch_flag_i = 1'b1;
        branch_target_i = 32'hFFFF_FFFC;
        step();
        branch_flag_i = 1'b0;
        branch_target_i = '0;
        probe();
        chk("wrap_top_addr", ibus_addr, 32'hFFFF_FFFC);
        step();
        probe();
        chk("wrap_zero_addr", ibus_addr, 32'h0);
        step();

        rst = 1'b1;
        step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
